max7219_display_sequencer: RTL and testbench

Sequences all traffic on the clock's three-wire serial display bus (data, load, shift clock) to a MAX7219-style 7-segment driver. After reset it issues a fixed configuration sequence, then on each time-update request writes the four BCD digits (HH:MM). It sits between the timekeeping logic and the `uo_out[2:0]` display pins, and owns the bus exclusively. Update requests arriving mid-transfer are coalesced rather than dropped.

---
 rtl/max7219_display_sequencer_pkg.sv | 50 +++++
 rtl/max7219_display_sequencer_if.sv | 9 +
 rtl/max7219_display_sequencer_serial_word_tx.sv | 87 ++++++++
 rtl/max7219_display_sequencer.sv | 150 +++++++++++++++
 tb/tb_max7219_display_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/max7219_display_sequencer_pkg.sv
// rtl/max7219_display_sequencer_pkg.sv - register map, word tables and FSM encoding for the display sequencer
package display_pkg;

    localparam logic [7:0] REG_DIGIT0    = 8'h01;
    localparam logic [7:0] REG_DIGIT1    = 8'h02;
    localparam logic [7:0] REG_DIGIT2    = 8'h03;
    localparam logic [7:0] REG_DIGIT3    = 8'h04;
    localparam logic [7:0] REG_DECODE    = 8'h09;
    localparam logic [7:0] REG_INTENSITY = 8'h0A;
    localparam logic [7:0] REG_SCAN      = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
    localparam logic [7:0] REG_TEST      = 8'h0F;

    localparam int INIT_LEN    = 5;
    localparam int REFRESH_LEN = 4;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_REFRESH,
        ST_PAUSE
    } seq_state_e;

    function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] intensity);
        logic [15:0] w;
        case (idx)
            3'd0:    w = {REG_SHUTDOWN, 8'h01};
            3'd1:    w = {REG_SCAN, 8'h03};
            3'd2:    w = {REG_DECODE, 8'hFF};
            3'd3:    w = {REG_INTENSITY, 4'h0, intensity};
            default: w = {REG_TEST, 8'h00};
        endcase
        return w;
    endfunction

    // Code-B value 0xF blanks the digit, used for a leading zero in the hours.
    function automatic logic [15:0] refresh_word(input logic [1:0] idx, input logic [7:0] hours,
                                                 input logic [7:0] minutes, input logic blank);
        logic [15:0] w;
        case (idx)
            2'd0:    w = {REG_DIGIT0, 4'h0, minutes[3:0]};
            2'd1:    w = {REG_DIGIT1, 4'h0, minutes[7:4]};
            2'd2:    w = {REG_DIGIT2, 4'h0, hours[3:0]};
            default: w = (blank && hours[7:4] == 4'h0) ? {REG_DIGIT3, 8'h0F}
                                                       : {REG_DIGIT3, 4'h0, hours[7:4]};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/max7219_display_sequencer_if.sv
// rtl/max7219_display_sequencer_if.sv - three-wire serial display bus (data, load, shift clock)
interface max7219_display_sequencer_if;
    logic serial_dout;
    logic serial_load;
    logic serial_clk;

    modport master (output serial_dout, output serial_load, output serial_clk);
    modport slave  (input serial_dout, input serial_load, input serial_clk);
endinterface

// File: rtl/max7219_display_sequencer_serial_word_tx.sv
// rtl/max7219_display_sequencer_serial_word_tx.sv - shifts one 16-bit word out as a 35-phase load/clk/data frame
module serial_word_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] word,
    output logic        done,
    max7219_display_sequencer_if.master bus
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    // Phase 0 is the load lead-in, phases 1..32 alternate clk low/high per bit,
    // 33 is the clk-low tail and 34 the load-high inter-word gap.
    localparam logic [5:0] STEP_GAP = 6'd34;

    logic        active_q, active_d;
    logic [5:0]  step_q, step_d;
    logic [7:0]  div_q, div_d;
    logic [15:0] word_q, word_d;
    logic        load_q, load_d;
    logic        sclk_q, sclk_d;
    logic        dout_q, dout_d;

    always_comb begin
        active_d = active_q;
        step_d   = step_q;
        div_d    = div_q;
        word_d   = word_q;
        done     = 1'b0;

        if (active_q) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (step_q == STEP_GAP) begin
                    done     = 1'b1;
                    active_d = 1'b0;
                end else begin
                    step_d = step_q + 6'd1;
                end
            end else begin
                div_d = div_q + 8'd1;
            end
        end

        if (start) begin
            active_d = 1'b1;
            step_d   = '0;
            div_d    = '0;
            word_d   = word;
        end

        // Pins are registered from the next-phase values so they change cleanly on phase boundaries.
        load_d = !active_d || (step_d == STEP_GAP);
        sclk_d = active_d && !step_d[0] && (step_d >= 6'd2) && (step_d <= 6'd32);
        dout_d = dout_q;
        if (active_d && step_d[0] && (step_d <= 6'd31)) begin
            dout_d = word_d[~step_d[4:1]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            step_q   <= '0;
            div_q    <= '0;
            word_q   <= '0;
            load_q   <= 1'b1;
            sclk_q   <= 1'b0;
            dout_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            step_q   <= step_d;
            div_q    <= div_d;
            word_q   <= word_d;
            load_q   <= load_d;
            sclk_q   <= sclk_d;
            dout_q   <= dout_d;
        end
    end

    assign bus.serial_load = load_q;
    assign bus.serial_clk  = sclk_q;
    assign bus.serial_dout = dout_q;

endmodule

// File: rtl/max7219_display_sequencer.sv
// rtl/max7219_display_sequencer.sv - init then HH:MM refresh sequencer for a MAX7219 bus; BLANK_LEADING_ZERO_EN blanks hours tens 0
module max7219_display_sequencer
    import display_pkg::*;
#(
    parameter int         CLK_DIV   = 4,
    parameter logic [3:0] INTENSITY = 4'h8
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_en,
    input  logic       i_update,
    input  logic [7:0] i_hours_bcd,
    input  logic [7:0] i_minutes_bcd,
    output logic       o_busy,
    max7219_display_sequencer_if.master bus
);

`ifdef BLANK_LEADING_ZERO_EN
    localparam logic BLANK_EN = 1'b1;
`else
    localparam logic BLANK_EN = 1'b0;
`endif

    localparam logic [2:0] INIT_LAST    = 3'(INIT_LEN - 1);
    localparam logic [2:0] REFRESH_LAST = 3'(REFRESH_LEN - 1);

    seq_state_e  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        inflight_q, inflight_d;
    logic        pending_q, pending_d;
    logic        mode_refresh_q, mode_refresh_d;
    logic [15:0] shadow_q, shadow_d;

    logic        tx_start;
    logic [15:0] tx_word;
    logic        tx_done;
    logic        refresh_go;
    logic        begin_refresh;
    logic [2:0]  last_idx;
    logic [2:0]  next_idx;

    function automatic logic [15:0] seq_word(input logic refresh, input logic [2:0] idx,
                                             input logic [15:0] shadow);
        return refresh ? refresh_word(idx[1:0], shadow[15:8], shadow[7:0], BLANK_EN)
                       : init_word(idx, INTENSITY);
    endfunction

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        inflight_d     = inflight_q;
        pending_d      = pending_q | i_update;
        mode_refresh_d = mode_refresh_q;
        shadow_d       = shadow_q;
        tx_start       = 1'b0;
        tx_word        = '0;
        begin_refresh  = 1'b0;
        refresh_go     = i_en && (pending_q || i_update);
        last_idx       = mode_refresh_q ? REFRESH_LAST : INIT_LAST;
        next_idx       = idx_q + 3'd1;

        case (state_q)
            ST_INIT, ST_REFRESH: begin
                if (!inflight_q) begin
                    // Only reached straight out of reset, before the first init word.
                    if (i_en) begin
                        tx_start   = 1'b1;
                        tx_word    = seq_word(mode_refresh_q, idx_q, shadow_q);
                        inflight_d = 1'b1;
                    end
                end else if (tx_done) begin
                    if (idx_q == last_idx) begin
                        if (refresh_go) begin
                            begin_refresh = 1'b1;
                        end else begin
                            state_d    = ST_IDLE;
                            inflight_d = 1'b0;
                        end
                    end else begin
                        idx_d = next_idx;
                        if (i_en) begin
                            tx_start = 1'b1;
                            tx_word  = seq_word(mode_refresh_q, next_idx, shadow_q);
                        end else begin
                            state_d    = ST_PAUSE;
                            inflight_d = 1'b0;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (i_en) begin
                    tx_start   = 1'b1;
                    tx_word    = seq_word(mode_refresh_q, idx_q, shadow_q);
                    inflight_d = 1'b1;
                    state_d    = mode_refresh_q ? ST_REFRESH : ST_INIT;
                end
            end
            default: begin
                if (refresh_go) begin
                    begin_refresh = 1'b1;
                end
            end
        endcase

        // The first refresh word uses the live inputs since the shadow only loads at this edge.
        if (begin_refresh) begin
            state_d        = ST_REFRESH;
            mode_refresh_d = 1'b1;
            idx_d          = '0;
            inflight_d     = 1'b1;
            pending_d      = 1'b0;
            shadow_d       = {i_hours_bcd, i_minutes_bcd};
            tx_start       = 1'b1;
            tx_word        = refresh_word(2'd0, i_hours_bcd, i_minutes_bcd, BLANK_EN);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= ST_INIT;
            idx_q          <= '0;
            inflight_q     <= 1'b0;
            pending_q      <= 1'b0;
            mode_refresh_q <= 1'b0;
            shadow_q       <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            inflight_q     <= inflight_d;
            pending_q      <= pending_d;
            mode_refresh_q <= mode_refresh_d;
            shadow_q       <= shadow_d;
        end
    end

    assign o_busy = (state_q != ST_IDLE) || pending_q;

    serial_word_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .start (tx_start),
        .word  (tx_word),
        .done  (tx_done),
        .bus   (bus)
    );

endmodule

// File: tb/tb_max7219_display_sequencer.sv
// tb/tb_max7219_display_sequencer.sv - self-checking bench for max7219_display_sequencer with a bus-level frame and word model
module tb_max7219_display_sequencer;

    localparam int P = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       upd = 1'b0;
    logic [7:0] hrs = 8'h00;
    logic [7:0] mins = 8'h00;
    logic       busy;

    max7219_display_sequencer_if bus ();

    max7219_display_sequencer #(
        .CLK_DIV   (P),
        .INTENSITY (4'h8)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_en          (en),
        .i_update      (upd),
        .i_hours_bcd   (hrs),
        .i_minutes_bcd (mins),
        .o_busy        (busy),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];
    int commits = 0;
    int falls = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic push_init();
        exp_q.push_back(16'h0C01);
        exp_q.push_back(16'h0B03);
        exp_q.push_back(16'h09FF);
        exp_q.push_back(16'h0A08);
        exp_q.push_back(16'h0F00);
    endtask

    task automatic push_refresh(input logic [7:0] h, input logic [7:0] m);
        logic [7:0] tens_code;
        tens_code = {4'h0, h[7:4]};
`ifdef BLANK_LEADING_ZERO_EN
        if (h[7:4] == 4'h0) tens_code = 8'h0F;
`endif
        exp_q.push_back({8'h01, 4'h0, m[3:0]});
        exp_q.push_back({8'h02, 4'h0, m[7:4]});
        exp_q.push_back({8'h03, 4'h0, h[3:0]});
        exp_q.push_back({8'h04, tens_code});
    endtask

    // Frame model: phase number since load fell fixes what load/clk must be; bits are
    // taken on clk rising and a word is committed on load rising.
    logic        prev_load = 1'b1;
    logic        prev_clk = 1'b0;
    logic [15:0] shreg = '0;
    int          nbits = 0;
    bit          in_frame = 1'b0;
    int          t = 0;
    int          step = 0;
    logic        exp_load;
    logic        exp_clk;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_idle_pins", 32'({bus.serial_load, bus.serial_clk}), 32'h2);
            in_frame = 1'b0;
            nbits = 0;
        end else begin
            if (in_frame) begin
                t++;
                if (t == 35 * P) in_frame = 1'b0;
            end
            if (prev_load && !bus.serial_load) begin
                in_frame = 1'b1;
                t = 0;
                nbits = 0;
                falls++;
            end
            if (in_frame) begin
                step = t / P;
                exp_load = (step == 34);
                exp_clk = (step >= 2) && (step <= 32) && (step % 2 == 0);
                check("frame_pins", 32'({bus.serial_load, bus.serial_clk}), 32'({exp_load, exp_clk}));
            end else begin
                check("idle_pins", 32'({bus.serial_load, bus.serial_clk}), 32'h2);
            end
            if (!prev_clk && bus.serial_clk) begin
                shreg = {shreg[14:0], bus.serial_dout};
                nbits++;
            end
            if (!prev_load && bus.serial_load) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %04h want none", shreg);
                end else begin
                    check("word", 32'(shreg), 32'(exp_q.pop_front()));
                    check("word_bits", 32'(nbits), 32'd16);
                end
                commits++;
            end
        end
        prev_load = bus.serial_load;
        prev_clk = bus.serial_clk;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_update(input logic [7:0] h, input logic [7:0] m);
        hrs = h;
        mins = m;
        upd = 1'b1;
        tick();
        upd = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    int c0;
    int f0;
    int lows;
    int guard;

    initial begin
        // Reset state and init sequence
        tick();
        tick();
        check("reset_pins", 32'({bus.serial_load, bus.serial_clk, bus.serial_dout}), 32'h4);
        check("reset_busy", 32'(busy), 32'd1);
        push_init();
        @(negedge clk);
        #1 rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 350; i++) begin
            tick();
            if (!busy) lows++;
        end
        check("init_busy_held", 32'(lows), 32'd0);
        tick();
        check("init_busy_drop", 32'(busy), 32'd0);
        check("init_word_count", 32'(commits), 32'd5);
        check("init_words_left", 32'(exp_q.size()), 32'd0);

        // Idle refresh with hand-computed words and one-cycle load latency
        exp_q.push_back(16'h0105);
        exp_q.push_back(16'h0204);
        exp_q.push_back(16'h0309);
`ifdef BLANK_LEADING_ZERO_EN
        exp_q.push_back(16'h040F);
`else
        exp_q.push_back(16'h0400);
`endif
        c0 = commits;
        pulse_update(8'h09, 8'h45);
        check("update_latency_load", 32'(bus.serial_load), 32'd0);
        wait_idle("refresh1_idle", 400);
        check("refresh1_word_count", 32'(commits - c0), 32'd4);
        check("refresh1_words_left", 32'(exp_q.size()), 32'd0);

        // Three updates mid-refresh coalesce into one follow-up refresh
        c0 = commits;
        push_refresh(8'h12, 8'h34);
        pulse_update(8'h12, 8'h34);
        repeat (50) tick();
        pulse_update(8'h12, 8'h40);
        repeat (50) tick();
        pulse_update(8'h12, 8'h45);
        repeat (50) tick();
        pulse_update(8'h12, 8'h46);
        check("coalesce_busy", 32'(busy), 32'd1);
        push_refresh(8'h12, 8'h46);
        wait_idle("coalesce_idle", 800);
        check("coalesce_word_count", 32'(commits - c0), 32'd8);
        check("coalesce_words_left", 32'(exp_q.size()), 32'd0);

        // Enable dropped during word 2 of a refresh
        c0 = commits;
        push_refresh(8'h23, 8'h58);
        pulse_update(8'h23, 8'h58);
        repeat (90) tick();
        en = 1'b0;
        f0 = falls;
        repeat (300) tick();
        check("pause_no_load_fall", 32'(falls - f0), 32'd0);
        check("pause_word_count", 32'(commits - c0), 32'd2);
        check("pause_busy", 32'(busy), 32'd1);
        en = 1'b1;
        tick();
        check("resume_load", 32'(bus.serial_load), 32'd0);
        wait_idle("resume_idle", 400);
        check("resume_word_count", 32'(commits - c0), 32'd4);
        check("resume_words_left", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while a word is on the wire
        c0 = commits;
        pulse_update(8'h11, 8'h22);
        repeat (20) tick();
        guard = 0;
        while (!bus.serial_clk && guard < 10) begin
            tick();
            guard++;
        end
        check("reset_mid_clk_high", 32'(bus.serial_clk), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_pins", 32'({bus.serial_load, bus.serial_clk, bus.serial_dout}), 32'h4);
        check("async_reset_busy", 32'(busy), 32'd1);
        exp_q.delete();
        push_init();
        repeat (3) tick();
        #1 rst_n = 1'b1;
        repeat (351) tick();
        check("reinit_busy_drop", 32'(busy), 32'd0);
        check("reinit_word_count", 32'(commits - c0), 32'd5);
        check("reinit_words_left", 32'(exp_q.size()), 32'd0);

        // Update on the final cycle of a refresh chains straight into the next one
        c0 = commits;
        lows = 0;
        push_refresh(8'h07, 8'h31);
        pulse_update(8'h07, 8'h31);
        for (int i = 0; i < 279; i++) begin
            if (!busy) lows++;
            tick();
        end
        check("final_cycle_gap", 32'(bus.serial_load), 32'd1);
        push_refresh(8'h07, 8'h32);
        pulse_update(8'h07, 8'h32);
        check("back_to_back_start", 32'(bus.serial_load), 32'd0);
        for (int i = 0; i < 279; i++) begin
            if (!busy) lows++;
            tick();
        end
        check("chain_busy_held", 32'(lows), 32'd0);
        wait_idle("chain_idle", 100);
        check("chain_word_count", 32'(commits - c0), 32'd8);
        check("chain_words_left", 32'(exp_q.size()), 32'd0);

        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
